conv_weight_writer: RTL

- Writer-side counterpart of the convolution weight ROM reader.
- Accepts a stream of DATA_WIDTH-bit weight words over a valid/ready handshake and packs F words into one F*DATA_WIDTH row.
- Writes each completed row into the weight RAM's write port at addresses 0..ROWS-1.
- Sits between the host/UART weight-download path and the conv weight memory. Signals done when all ROWS rows have been written.

---
 rtl/conv_pkg.sv | 18 +
 rtl/row_packer.sv | 48 ++++
 rtl/conv_weight_writer.sv | 118 +++++++++++
 3 files changed

// File: rtl/conv_pkg.sv
// Shared convolution weight-memory constants and the writer FSM state encoding.
// Defaults match the weight ROM reader so both sides agree on row geometry.
package conv_pkg;

  localparam int DATA_WIDTH_DEF = 16;
  localparam int F_DEF          = 64;
  localparam int ROWS_DEF       = 6;
  localparam int ADDR_WIDTH_DEF = 3;
  localparam int ROW_WIDTH      = F_DEF * DATA_WIDTH_DEF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/row_packer.sv
// Packs F accepted words into one row, first word in the most-significant lane.
// row_next and row_full are combinational so the writer can capture a complete row on the last push.
module row_packer #(
  parameter int DATA_WIDTH = 16,
  parameter int F          = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clr,
  input  logic                    push,
  input  logic [DATA_WIDTH-1:0]   data,
  output logic [F*DATA_WIDTH-1:0] row_next,
  output logic                    row_full
);

  localparam int CW = (F > 1) ? $clog2(F) : 1;

  logic [CW-1:0]           word_cnt;
  logic [F*DATA_WIDTH-1:0] row;

  assign row_full = push && (word_cnt == CW'(F - 1));

  always_comb begin
    row_next = row;
    for (int k = 0; k < F; k++) begin
      if (push && (word_cnt == CW'(k))) begin
        row_next[(F-1-k)*DATA_WIDTH +: DATA_WIDTH] = data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      word_cnt <= '0;
      row      <= '0;
    end else begin
      if (clr) begin
        word_cnt <= '0;
      end else if (push) begin
        word_cnt <= row_full ? '0 : word_cnt + 1'b1;
      end
      if (push) begin
        row <= row_next;
      end
    end
  end

endmodule

// File: rtl/conv_weight_writer.sv
// Streams weight words into RAM rows 0..ROWS-1; each row is written the cycle after its last word.
// s_ready drops for the one-cycle WRITE bubble and outside a load; s_last framing errors are sticky in err.
module conv_weight_writer
  import conv_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int F          = F_DEF,
  parameter int ROWS       = ROWS_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    s_valid,
  input  logic [DATA_WIDTH-1:0]   s_data,
  input  logic                    s_last,
  output logic                    s_ready,
  output logic                    wr_en,
  output logic [ADDR_WIDTH-1:0]   wr_addr,
  output logic [F*DATA_WIDTH-1:0] wr_data,
  output logic                    busy,
  output logic                    done,
  output logic                    err
);

  localparam int ROW_W = F * DATA_WIDTH;

  state_t                state;
  logic [ADDR_WIDTH-1:0] row_cnt;
  logic                  push;
  logic                  clr;
  logic                  row_full;
  logic                  last_row;
  logic [ROW_W-1:0]      row_next;

  // s_ready is only ever high in FILL, so it alone qualifies acceptance
  assign push     = s_valid && s_ready;
  assign clr      = start && ((state == IDLE) || (state == DONE));
  assign last_row = (row_cnt == ADDR_WIDTH'(ROWS - 1));

  row_packer #(
    .DATA_WIDTH (DATA_WIDTH),
    .F          (F)
  ) u_packer (
    .clk      (clk),
    .reset    (reset),
    .clr      (clr),
    .push     (push),
    .data     (s_data),
    .row_next (row_next),
    .row_full (row_full)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      row_cnt <= '0;
      s_ready <= 1'b0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state   <= FILL;
            row_cnt <= '0;
            err     <= 1'b0;
            done    <= 1'b0;
            busy    <= 1'b1;
            s_ready <= 1'b1;
          end
        end
        FILL: begin
          if (push) begin
            if (s_last && !(row_full && last_row)) begin
              // premature end of load: drop the partial row, keep rows already written
              err     <= 1'b1;
              state   <= IDLE;
              s_ready <= 1'b0;
              busy    <= 1'b0;
            end else if (row_full) begin
              if (last_row && !s_last) begin
                err <= 1'b1;
              end
              state   <= WRITE;
              s_ready <= 1'b0;
              wr_en   <= 1'b1;
              wr_addr <= row_cnt;
              wr_data <= row_next;
            end
          end
        end
        WRITE: begin
          if (last_row) begin
            state <= DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end else begin
            row_cnt <= row_cnt + 1'b1;
            state   <= FILL;
            s_ready <= 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          s_ready <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
